// File: rtl/nr_mant_divider.sv
// rtl/nr_mant_divider.sv - non-restoring 24-bit mantissa divider, 70-bit quotient
// Optional sticky output enabled by defining NRD_STICKY_EN.
module nr_mant_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] in1,
  input  logic [23:0] in2,
  output logic        busy,
  output logic        done,
  output logic [69:0] out1,
  output logic        div_zero
`ifdef NRD_STICKY_EN
  ,
  output logic        sticky
`endif
);

  typedef enum logic [1:0] {IDLE, ITER, CORRECT, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic [23:0] a_sh;
  logic [23:0] b;
  logic [25:0] r;
  logic [25:0] r_shift;
  logic [25:0] r_iter;
  logic [25:0] r_corr;

  // Dividend is {A, 46'b0}: once A has shifted out the incoming bits are zero.
  always_comb begin
    r_shift = {r[24:0], a_sh[23]};
    if (r[25]) r_iter = r_shift + {2'b00, b};
    else       r_iter = r_shift - {2'b00, b};
    r_corr = r[25] ? (r + {2'b00, b}) : r;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A zero divisor skips ITER and writes its result in CORRECT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (in2 == 24'd0) ? CORRECT : ITER;
      ITER:    if (cnt == 7'd69) state_nxt = CORRECT;
      CORRECT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 7'd0;
      a_sh     <= 24'd0;
      b        <= 24'd0;
      r        <= 26'd0;
      out1     <= 70'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= in1;
            b        <= in2;
            r        <= 26'd0;
            cnt      <= 7'd0;
            out1     <= 70'd0;
            div_zero <= (in2 == 24'd0);
          end
        end
        ITER: begin
          r    <= r_iter;
          a_sh <= {a_sh[22:0], 1'b0};
          out1 <= {out1[68:0], ~r_iter[25]};
          cnt  <= cnt + 7'd1;
        end
        CORRECT: begin
          r <= r_corr;
          if (div_zero) out1 <= {70{1'b1}};
        end
        default: ;
      endcase
    end
  end

`ifdef NRD_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
    end else if (state == IDLE && start) begin
      sticky <= 1'b0;
    end else if (state == CORRECT) begin
      sticky <= !div_zero && (r_corr != 26'd0);
    end
  end
`endif

endmodule

// File: tb/tb_nr_mant_divider.sv
// tb/tb_nr_mant_divider.sv - self-checking bench for nr_mant_divider
// Reference quotient is plain wide division of {A, 46'b0} by B.
module tb_nr_mant_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] in1;
  logic [23:0] in2;
  logic        busy;
  logic        done;
  logic [69:0] out1;
  logic        div_zero;
`ifdef NRD_STICKY_EN
  logic        sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nr_mant_divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .out1     (out1),
    .div_zero (div_zero)
`ifdef NRD_STICKY_EN
    ,
    .sticky   (sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [69:0] model_q(input logic [23:0] a, input logic [23:0] b);
    logic [69:0] num;
    num = {a, 46'd0};
    if (b == 24'd0) return {70{1'b1}};
    return num / {46'd0, b};
  endfunction

  function automatic bit model_sticky(input logic [23:0] a, input logic [23:0] b);
    logic [69:0] num;
    num = {a, 46'd0};
    if (b == 24'd0) return 1'b0;
    return (num % {46'd0, b}) != 70'd0;
  endfunction

  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input string name,
                        output logic [69:0] q_obs);
    int lat;
    bit seen;
    int exp_lat;
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    q_obs = out1;
    exp_lat = (b == 24'd0) ? 2 : 72;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no done within 200 cycles", name);
    end else if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (out1 !== model_q(a, b)) begin
      n_fail++;
      $display("FAIL %s quotient: got %h expected %h", name, out1, model_q(a, b));
    end
    n_checks++;
    if (div_zero !== (b == 24'd0)) begin
      n_fail++;
      $display("FAIL %s div_zero: got %b expected %b", name, div_zero, (b == 24'd0));
    end
`ifdef NRD_STICKY_EN
    n_checks++;
    if (sticky !== model_sticky(a, b)) begin
      n_fail++;
      $display("FAIL %s sticky: got %b expected %b", name, sticky, model_sticky(a, b));
    end
`endif
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post-done: done=%b busy=%b expected 0 0", name, done, busy);
    end
    n_checks++;
    if (out1 !== model_q(a, b)) begin
      n_fail++;
      $display("FAIL %s hold: got %h expected %h", name, out1, model_q(a, b));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in1 = 24'h800000; in2 = 24'h800000;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out1 !== 70'd0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b out1=%h div_zero=%b expected all 0", busy, done, out1, div_zero);
    end
`ifdef NRD_STICKY_EN
    n_checks++;
    if (sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset sticky: got %b expected 0", sticky);
    end
`endif
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_vectors();
    logic [69:0] q;
    run_op(24'h800000, 24'h800000, "one", q);
    n_checks++;
    if (q !== 70'h4000_0000_0000) begin
      n_fail++;
      $display("FAIL one const: got %h expected 4000_0000_0000", q);
    end
    run_op(24'hC00000, 24'h800000, "one_half", q);
    n_checks++;
    if (q !== 70'h6000_0000_0000) begin
      n_fail++;
      $display("FAIL one_half const: got %h expected 6000_0000_0000", q);
    end
    run_op(24'h800000, 24'hC00000, "two_thirds", q);
    n_checks++;
    if (q !== 70'h2AAA_AAAA_AAAA) begin
      n_fail++;
      $display("FAIL two_thirds const: got %h expected 2AAA_AAAA_AAAA", q);
    end
  endtask

  task automatic test_div_zero();
    logic [69:0] q;
    run_op(24'h123456, 24'h000000, "div_zero", q);
    run_op(24'h800000, 24'h800000, "after_zero", q);
  endtask

  task automatic test_back_to_back();
    int n_done;
    logic [69:0] q_at_done;
    @(negedge clk);
    in1 = 24'hFFFFFF; in2 = 24'h800000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0; q_at_done = '0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (i >= 10 && i < 20) begin
        start = 1'b1; in1 = 24'h9ABCDE; in2 = 24'h000000;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        q_at_done = out1;
      end
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL held_start done count: got %0d expected 1", n_done);
    end
    n_checks++;
    if (q_at_done !== 70'h7FFF_FF80_0000) begin
      n_fail++;
      $display("FAIL held_start quotient: got %h expected 7FFF_FF80_0000", q_at_done);
    end
  endtask

  task automatic test_start_at_done();
    logic [69:0] q;
    bit seen;
    @(negedge clk);
    in1 = 24'hA00000; in2 = 24'h900000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    in1 = 24'h800000; in2 = 24'h000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!seen || busy !== 1'b0 || div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL start_at_done: seen=%b busy=%b div_zero=%b expected 1 0 0", seen, busy, div_zero);
    end
    run_op(24'hFEDCBA, 24'h812345, "idle_after_done", q);
  endtask

  task automatic test_abort();
    logic [69:0] q;
    int n_done;
    @(negedge clk);
    in1 = 24'hC00000; in2 = 24'hA00000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out1 !== 70'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy=%b out1=%h done=%b expected 0 0 0", busy, out1, done);
    end
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL abort quiet: got %0d active cycles expected 0", n_done);
    end
    run_op(24'hC00000, 24'hA00000, "after_abort", q);
  endtask

  task automatic test_random();
    logic [69:0] q;
    logic [23:0] a;
    logic [23:0] b;
    for (int i = 0; i < 12; i++) begin
      a = 24'($urandom_range(24'hFFFFFF, 24'h800000));
      if (i < 8) b = 24'($urandom_range(24'hFFFFFF, 24'h800000));
      else       b = 24'($urandom_range(24'hFFFFFF, 1));
      run_op(a, b, "random", q);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    test_reset();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_start_at_done();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
